fetch_stage: RTL

Instruction-fetch stage: owns the program counter, issues requests to instruction memory over a req/ack handshake, and loads the IF/ID pipeline register. It sits directly upstream of the branch predictor. It consumes the predictor's redirect (`pc_control`/`pc_address`) and `if_id_flush`, and supplies the decode-side PC and opcode the predictor reads. A one-entry skid buffer absorbs a fetch response that arrives while decode is stalled.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 54 +++++
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// PC step and the default bubble instruction.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2,
    FULL = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP           = 32'd4;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  // Instruction addresses are word aligned; the low two bits are ignored.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: reset, flush, stall (hold), load,
// otherwise a bubble. The instruction field is forced to the NOP value
// whenever the entry is invalid so the output never needs a mux.
import fetch_pkg::*;

module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic [31:0] load_instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        valid_r;
  logic [31:0] pc_r;
  logic [31:0] instr_r;

  // IF/ID state update with flush > stall > load > bubble priority.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_r <= 1'b0;
      pc_r    <= 32'h0000_0000;
      instr_r <= NOP_INSTR;
    end else if (flush_i) begin
      valid_r <= 1'b0;
      pc_r    <= pc_r;
      instr_r <= NOP_INSTR;
    end else if (stall_i) begin
      valid_r <= valid_r;
      pc_r    <= pc_r;
      instr_r <= instr_r;
    end else if (load_i) begin
      valid_r <= 1'b1;
      pc_r    <= load_pc_i;
      instr_r <= load_instr_i;
    end else begin
      valid_r <= 1'b0;
      pc_r    <= pc_r;
      instr_r <= NOP_INSTR;
    end
  end

  assign valid_o = valid_r;
  assign pc_o    = pc_r;
  assign instr_o = instr_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, req/ack instruction-memory
// handshake, one-entry skid buffer for responses landing during a decode
// stall, and the IF/ID register feeding decode and the branch predictor.
import fetch_pkg::*;

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        pc_control_i,
  input  logic [31:0] pc_address_i,
  input  logic        if_id_flush_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o
);

  fetch_state_e state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  req_addr_r, req_addr_s;
  logic [31:0]  skid_pc_r, skid_pc_s;
  logic [31:0]  skid_instr_r, skid_instr_s;
  logic         req_r, req_s;

  logic [31:0]  target_s;
  logic         done_s;
  logic         load_s;
  logic [31:0]  load_pc_s;
  logic [31:0]  load_instr_s;
  logic         id_flush_s;

  assign target_s   = align_pc(pc_address_i);
  assign done_s     = req_r && imem_ack_i;
  assign id_flush_s = pc_control_i || if_id_flush_i;

  // Next-state, PC, request address, skid and IF/ID load decisions.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    req_addr_s   = req_addr_r;
    skid_pc_s    = skid_pc_r;
    skid_instr_s = skid_instr_r;
    load_s       = 1'b0;
    load_pc_s    = skid_pc_r;
    load_instr_s = skid_instr_r;

    case (state_r)
      IDLE: begin
        if (pc_control_i) begin
          pc_s = target_s;
        end else if (!stall_i) begin
          req_addr_s = pc_r;
          state_s    = BUSY;
        end else begin
          state_s = IDLE;
        end
      end

      BUSY: begin
        if (done_s) begin
          if (pc_control_i) begin
            // Response belongs to the old path: drop it.
            pc_s    = target_s;
            state_s = IDLE;
          end else if (stall_i) begin
            skid_pc_s    = req_addr_r;
            skid_instr_s = imem_rdata_i;
            pc_s         = pc_r + PC_STEP;
            state_s      = FULL;
          end else begin
            load_s       = 1'b1;
            load_pc_s    = req_addr_r;
            load_instr_s = imem_rdata_i;
            pc_s         = pc_r + PC_STEP;
            req_addr_s   = pc_r + PC_STEP;
          end
        end else if (pc_control_i) begin
          // Request must stay up with its address until acked.
          pc_s    = target_s;
          state_s = DROP;
        end else begin
          state_s = BUSY;
        end
      end

      DROP: begin
        if (pc_control_i) begin
          pc_s = target_s;
        end else begin
          pc_s = pc_r;
        end
        if (done_s) begin
          if (pc_control_i) begin
            req_addr_s = target_s;
          end else begin
            req_addr_s = pc_r;
          end
          state_s = BUSY;
        end else begin
          state_s = DROP;
        end
      end

      FULL: begin
        if (pc_control_i) begin
          pc_s    = target_s;
          state_s = IDLE;
        end else if (!stall_i) begin
          load_s     = 1'b1;
          req_addr_s = pc_r;
          state_s    = BUSY;
        end else begin
          state_s = FULL;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    req_s = (state_s == BUSY) || (state_s == DROP);
  end

  // Fetch-side registers; the request strobe is registered from the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC;
      req_addr_r   <= 32'h0000_0000;
      skid_pc_r    <= 32'h0000_0000;
      skid_instr_r <= 32'h0000_0000;
      req_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      req_addr_r   <= req_addr_s;
      skid_pc_r    <= skid_pc_s;
      skid_instr_r <= skid_instr_s;
      req_r        <= req_s;
    end
  end

  assign imem_req_o  = req_r;
  assign imem_addr_o = req_addr_r;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .flush_i      (id_flush_s),
    .stall_i      (stall_i),
    .load_i       (load_s),
    .load_pc_i    (load_pc_s),
    .load_instr_i (load_instr_s),
    .valid_o      (id_valid_o),
    .pc_o         (id_pc_o),
    .instr_o      (id_instr_o)
  );

endmodule
